// File: rtl/ws2812_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ws2812_pkg                                                |
// | Brief    : Shared state encoding, frame length and default timing    |
// |            for the WS2812 single-wire serialiser.                    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package ws2812_pkg;

    localparam int FRAME_BITS = 24;

    // Default bit timing for a 10 MHz main clock.
    localparam int DEF_BIT_CYCLES   = 13;
    localparam int DEF_T0H_CYCLES   = 4;
    localparam int DEF_T1H_CYCLES   = 8;
    localparam int DEF_LATCH_CYCLES = 3000;

    typedef logic [1:0] ws_state_t;

    localparam ws_state_t ST_IDLE  = 2'd0;
    localparam ws_state_t ST_HIGH  = 2'd1;
    localparam ws_state_t ST_LOW   = 2'd2;
    localparam ws_state_t ST_LATCH = 2'd3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ws2812_tx                                                 |
// | Brief    : Serialises a GRB colour snapshot onto the WS2812 data     |
// |            line, followed by a latch (reset) low period.             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter bit AUTO_REFRESH = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       start,
    output logic       dout,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(max4(BIT_CYCLES, LATCH_CYCLES, T1H_CYCLES, 2) + 1);
    localparam int IDX_W = 5;

    generate
        if (!((T0H_CYCLES >= 1) && (T0H_CYCLES < T1H_CYCLES) &&
              (T1H_CYCLES < BIT_CYCLES) && (LATCH_CYCLES >= 1))) begin : g_param_check
            $error("ws2812_tx: illegal timing parameter combination");
        end
    endgenerate

    ws_state_t               r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [FRAME_BITS-1:0]   r_shift;
    logic                    r_quiet;
    logic                    r_done_pend;
    logic                    r_dout;
    logic                    r_busy;
    logic                    r_done;

    logic [CNT_W-1:0]        w_th;
    logic                    w_high_last;
    logic                    w_low_last;
    logic                    w_latch_last;
    logic                    w_go;

    assign w_th         = r_shift[FRAME_BITS-1] ? CNT_W'(T1H_CYCLES) : CNT_W'(T0H_CYCLES);
    assign w_high_last  = (r_cnt == (w_th - CNT_W'(1)));
    assign w_low_last   = (r_cnt == (CNT_W'(BIT_CYCLES) - w_th - CNT_W'(1)));
    assign w_latch_last = (r_cnt == CNT_W'(LATCH_CYCLES - 1));
    assign w_go         = AUTO_REFRESH || start;

    // Outputs are registered from the current state, so they trail the
    // FSM by one edge and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LATCH;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_quiet     <= 1'b1;
            r_done_pend <= 1'b0;
            r_dout      <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_dout      <= (r_state == ST_HIGH);
            r_busy      <= (r_state != ST_IDLE);
            r_done      <= r_done_pend;
            r_done_pend <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_shift <= {green, red, blue};
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_high_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_LOW;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (w_low_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        if (r_idx == IDX_W'(FRAME_BITS - 1)) begin
                            r_idx   <= '0;
                            r_state <= ST_LATCH;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (w_latch_last) begin
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                        // The resync latch after reset completes silently.
                        r_done_pend <= ~r_quiet;
                        r_quiet     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ws2812_tx                                              |
// | Brief    : Self-checking bench for ws2812_tx against a waveform model |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_ws2812_tx;

    localparam int BITC      = 10;
    localparam int T0H       = 3;
    localparam int T1H       = 7;
    localparam int LATCHC    = 20;
    localparam int FRAME_LEN = 24 * BITC + LATCHC;

    logic       clk = 1'b0;
    logic       reset, start, dout, busy, done;
    logic [7:0] red, green, blue;
    logic       ar_reset, ar_start, ar_dout, ar_busy, ar_done;
    logic [7:0] ar_red, ar_green, ar_blue;

    int n_pass  = 0;
    int n_total = 0;
    bit exp_wave [FRAME_LEN];

    always #5 clk = ~clk;

    ws2812_tx #(.BIT_CYCLES(BITC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
                .LATCH_CYCLES(LATCHC), .AUTO_REFRESH(1'b0)) dut (
        .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue),
        .start(start), .dout(dout), .busy(busy), .done(done));

    ws2812_tx #(.BIT_CYCLES(BITC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
                .LATCH_CYCLES(LATCHC), .AUTO_REFRESH(1'b1)) dut_ar (
        .clk(clk), .reset(ar_reset), .red(ar_red), .green(ar_green), .blue(ar_blue),
        .start(ar_start), .dout(ar_dout), .busy(ar_busy), .done(ar_done));

    // Reference: the line level for each cycle of a frame, from the first rise.
    function automatic void make_wave(input logic [23:0] grb);
        int p;
        int th;
        p = 0;
        for (int i = 23; i >= 0; i--) begin
            th = grb[i] ? T1H : T0H;
            for (int c = 0; c < BITC; c++) begin
                exp_wave[p] = (c < th);
                p++;
            end
        end
        for (int c = 0; c < LATCHC; c++) begin
            exp_wave[p] = 1'b0;
            p++;
        end
    endfunction

    task automatic test_post_reset_latch(input string tag);
        int hi_cnt;
        int dout_hi;
        int done_cnt;
        hi_cnt = 0; dout_hi = 0; done_cnt = 0;
        for (int j = 0; j < LATCHC; j++) begin
            @(negedge clk);
            if (busy) hi_cnt++;
            if (dout) dout_hi++;
            if (done) done_cnt++;
        end
        n_total++;
        if (hi_cnt !== LATCHC) $display("FAIL %s_latch_busy: busy-high cycles %0d, required %0d", tag, hi_cnt, LATCHC);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s_busy_drop: busy %b, required 0", tag, busy);
        else n_pass++;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (dout) dout_hi++;
        end
        n_total++;
        if (dout_hi !== 0) $display("FAIL %s_latch_dout: dout-high cycles %0d, required 0", tag, dout_hi);
        else n_pass++;
        n_total++;
        if (done_cnt !== 0) $display("FAIL %s_no_done: done pulses %0d, required 0", tag, done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({dout, busy, done} !== 3'b010)
            $display("FAIL reset_state: dout/busy/done %b%b%b, required 010", dout, busy, done);
        else n_pass++;
        reset = 1'b0;
        test_post_reset_latch("reset");
    endtask

    task automatic run_frame(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                             input bit disturb, input string tag);
        int  dout_err, busy_err, first_err, done_at, done_cnt, n_rise, gap_err, last_rise;
        bit  exp_d, exp_b;
        logic prev;
        make_wave({g, r, b});
        green = g; red = r; blue = b;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_total++;
        if ({dout, busy} !== 2'b00) $display("FAIL %s_latency: dout/busy %b%b one cycle after start, required 00", tag, dout, busy);
        else n_pass++;
        dout_err = 0; busy_err = 0; first_err = -1; done_at = -1; done_cnt = 0;
        n_rise = 0; gap_err = 0; last_rise = -1; prev = 1'b0;
        for (int k = 1; k <= FRAME_LEN + 8; k++) begin
            @(negedge clk);
            if (disturb && k == 5 * BITC + 2) begin start = 1'b1; red = ~red; end
            else start = 1'b0;
            exp_d = (k <= FRAME_LEN) ? exp_wave[k-1] : 1'b0;
            exp_b = (k <= FRAME_LEN);
            if (dout !== exp_d) begin dout_err++; if (first_err < 0) first_err = k; end
            if (busy !== exp_b) busy_err++;
            if (done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
            if (dout === 1'b1 && prev === 1'b0) begin
                if (last_rise >= 0 && (k - last_rise) != BITC) gap_err++;
                last_rise = k;
                n_rise++;
            end
            prev = dout;
        end
        n_total++;
        if (dout_err !== 0) $display("FAIL %s_dout: %0d wrong cycles (first at %0d), required 0", tag, dout_err, first_err);
        else n_pass++;
        n_total++;
        if (busy_err !== 0) $display("FAIL %s_busy: %0d wrong cycles, required 0", tag, busy_err);
        else n_pass++;
        n_total++;
        if (done_at !== FRAME_LEN + 1) $display("FAIL %s_done_pos: done at cycle %0d, required %0d", tag, done_at, FRAME_LEN + 1);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL %s_done_count: %0d pulses, required 1", tag, done_cnt);
        else n_pass++;
        n_total++;
        if (n_rise !== 24 || gap_err !== 0)
            $display("FAIL %s_bit_period: rises %0d bad gaps %0d, required 24 and 0", tag, n_rise, gap_err);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        run_frame(8'h80, 8'h00, 8'h01, 1'b0, "grb800001");
    endtask

    task automatic test_boundaries();
        run_frame(8'h00, 8'h00, 8'h00, 1'b0, "all_zero");
        run_frame(8'hFF, 8'hFF, 8'hFF, 1'b0, "all_ones");
    endtask

    task automatic test_ignore_start();
        logic [31:0] c;
        c = $urandom;
        run_frame(c[23:16], c[15:8], c[7:0], 1'b1, "ignore_start");
    endtask

    task automatic test_mid_reset();
        logic [31:0] c;
        c = $urandom;
        green = c[23:16]; red = c[15:8]; blue = c[7:0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (12 * BITC + 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({dout, busy, done} !== 3'b010)
            $display("FAIL midreset_state: dout/busy/done %b%b%b, required 010", dout, busy, done);
        else n_pass++;
        reset = 1'b0;
        test_post_reset_latch("midreset");
        c = $urandom;
        run_frame(c[23:16], c[15:8], c[7:0], 1'b0, "after_reset");
    endtask

    task automatic test_auto_refresh();
        int waited;
        int errs;
        bit exp_d, exp_b, exp_dn;
        waited = 0;
        while (ar_done !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (ar_done !== 1'b1) $display("FAIL auto_first_done: no done within %0d cycles, required a pulse", waited);
        else n_pass++;
        make_wave(24'hFFFFFF);
        for (int f = 0; f < 2; f++) begin
            errs = 0;
            for (int k = 1; k <= FRAME_LEN + 1; k++) begin
                @(negedge clk);
                exp_d  = (k <= FRAME_LEN) ? exp_wave[k-1] : 1'b0;
                exp_b  = (k <= FRAME_LEN);
                exp_dn = (k == FRAME_LEN + 1);
                if (ar_dout !== exp_d || ar_busy !== exp_b || ar_done !== exp_dn) errs++;
            end
            n_total++;
            if (errs !== 0) $display("FAIL auto_frame%0d: %0d wrong cycles, required 0", f, errs);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] c;
        for (int i = 0; i < 3; i++) begin
            c = $urandom;
            run_frame(c[23:16], c[15:8], c[7:0], 1'b0, "random");
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        red      = 8'h00; green    = 8'h00; blue    = 8'h00;
        ar_reset = 1'b1;
        ar_start = 1'b0;
        ar_red   = 8'hFF; ar_green = 8'hFF; ar_blue = 8'hFF;
        repeat (2) @(negedge clk);
        ar_reset = 1'b0;
        test_reset();
        test_basic_frame();
        test_boundaries();
        test_ignore_start();
        test_mid_reset();
        test_auto_refresh();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
